// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared definitions for the ID-stage hazard/stall unit: FSM state
//             encoding, default register-index width, zero-register constant
//             and the SAD wait counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_W_DEFAULT = 5;

  // Register index that is hard-wired to zero and never creates a hazard.
  localparam int ZERO_REG = 0;

  // Wide enough for SAD_LATENCY-1 up to 14 without wrapping.
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SAD_WAIT = 1'b1
  } hsu_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sad_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sad_wait_counter
//  Purpose  : Loadable down-counter timing the SAD_WAIT hold. Counts down to
//             zero and stops there; done flags the final wait cycle.
//  Ports    : clk, rst (async, active-high)
//             load       - load value this edge (has priority over counting)
//             load_value - value to load
//             value      - current count
//             done       - count == 1 (last hold cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module sad_wait_counter
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 done
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == CNT_WIDTH'(1));

endmodule : sad_wait_counter
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_unit
//  Purpose  : ID-stage hazard unit. Detects load-use hazards combinationally
//             and holds the pipeline for SAD_LATENCY-1 cycles after a
//             SAD-class op issues into EX. Drives the control-bubble stall,
//             PC / IF-ID enables and the IF-ID flush.
//  Ports    : clk, rst (async, active-high)
//             id_rs, id_rt, id_uses_rt, id_sad_op   - ID instruction info
//             idex_mem_read, idex_rt                - load in EX
//             branch_taken                          - redirect from EX
//             stall, pc_write, ifid_write, ifid_flush, busy
//             stall_cycles (only with HAZARD_STALL_STATS_EN defined)
//  Options  : HAZARD_STALL_STATS_EN - adds saturating 32-bit stall counter
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int SAD_LATENCY = 4,
  parameter int REG_W       = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_sad_op,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             branch_taken,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam bit             SAD_MULTI = (SAD_LATENCY > 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SAD_LATENCY - 1);

  hsu_state_e       state;
  hsu_state_e       state_next;
  logic             load_hazard;
  logic             stall_fsm;
  logic             busy_fsm;
  logic             cnt_load;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_value;

  assign load_hazard = idex_mem_read
                     & (idex_rt != REG_W'(ZERO_REG))
                     & ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_fsm  = 1'b0;
    busy_fsm   = 1'b0;
    cnt_load   = 1'b0;
    case (state)
      IDLE: begin
        // A taken branch squashes the ID instruction, so neither its hazard
        // nor its SAD issue matters this cycle.
        stall_fsm = load_hazard & ~branch_taken;
        if (id_sad_op & ~stall_fsm & ~branch_taken & SAD_MULTI) begin
          state_next = SAD_WAIT;
          cnt_load   = 1'b1;
        end
      end
      SAD_WAIT: begin
        stall_fsm = 1'b1;
        busy_fsm  = 1'b1;
        if (cnt_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  sad_wait_counter #(
    .CNT_WIDTH (CNT_W)
  ) u_sad_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (LOAD_VAL),
    .value      (cnt_value),
    .done       (cnt_done)
  );

  // Outputs are gated by rst so the pipeline runs freely while in reset,
  // independent of whatever the hazard inputs happen to be.
  assign stall      = stall_fsm & ~rst;
  assign busy       = busy_fsm & ~rst;
  assign pc_write   = ~stall;
  assign ifid_write = ~stall;
  assign ifid_flush = branch_taken & ~rst;

`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule : hazard_stall_unit
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_unit
//  Purpose  : Self-checking bench for hazard_stall_unit. Directed scenarios
//             followed by random stimulus, all compared against a small
//             cycle-level reference model (remaining-hold counter).
//  Options  : HAZARD_STALL_STATS_EN - also checks stall_cycles
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int SAD_LATENCY = 4;
  localparam int REG_W       = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, idex_rt;
  logic             id_uses_rt, id_sad_op, idex_mem_read, branch_taken;
  logic             stall, pc_write, ifid_write, ifid_flush, busy;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0]      stall_cycles;
`endif

  int tests  = 0;
  int failed = 0;

  // Reference model: number of forced hold cycles still owed, and the number
  // of stalled cycles seen since reset.
  int          wait_left = 0;
  logic [31:0] stat_cnt  = '0;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .SAD_LATENCY (SAD_LATENCY),
    .REG_W       (REG_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_sad_op     (id_sad_op),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .busy          (busy)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step(input logic mr, input logic [REG_W-1:0] xrt,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic urt, input logic sad, input logic bt);
    logic lh, es, eb;
    @(negedge clk);
    idex_mem_read = mr;
    idex_rt       = xrt;
    id_rs         = rs;
    id_rt         = rt;
    id_uses_rt    = urt;
    id_sad_op     = sad;
    branch_taken  = bt;
    #1;
    lh = mr && (xrt != 0) && ((xrt == rs) || (urt && (xrt == rt)));
    if (wait_left > 0) begin
      es = 1'b1;
      eb = 1'b1;
    end else begin
      es = lh && !bt;
      eb = 1'b0;
    end
    check("stall",      32'(stall),      32'(es));
    check("pc_write",   32'(pc_write),   32'(!es));
    check("ifid_write", 32'(ifid_write), 32'(!es));
    check("ifid_flush", 32'(ifid_flush), 32'(bt));
    check("busy",       32'(busy),       32'(eb));
`ifdef HAZARD_STALL_STATS_EN
    check("stall_cycles", stall_cycles, stat_cnt);
`endif
    @(posedge clk);
    if (es && stat_cnt != 32'hFFFF_FFFF) stat_cnt++;
    if (wait_left > 0) wait_left--;
    else if (sad && !es && !bt && SAD_LATENCY > 1) wait_left = SAD_LATENCY - 1;
  endtask

  initial begin
    rst = 1'b1;
    idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd0;
    id_uses_rt = 1'b0; id_sad_op = 1'b1; branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // In reset: outputs forced regardless of a live hazard and branch.
    check("rst_stall",      32'(stall),      32'd0);
    check("rst_pc_write",   32'(pc_write),   32'd1);
    check("rst_ifid_write", 32'(ifid_write), 32'd1);
    check("rst_ifid_flush", 32'(ifid_flush), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Load-use on rs, then bubble.
    step(1, 8, 8, 0, 0, 0, 0);
    step(0, 8, 8, 0, 0, 0, 0);
    // Load-use on rt with uses_rt.
    step(1, 6, 1, 6, 1, 0, 0);
    // Zero register never hazards; rt match ignored without uses_rt.
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 9, 3, 9, 0, 0, 0);

    // Single SAD op: 0 then 3 stall cycles then 0.
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);

    // Hazard + SAD + branch: branch wins, no SAD_WAIT entry.
    step(1, 4, 4, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Load-use on a SAD op defers the SAD issue by one cycle.
    step(1, 5, 5, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);

    // Back-to-back SAD ops: second waits in ID, issues when wait ends.
    repeat (5) step(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);

    // Branch during SAD_WAIT: flush shown, counting continues.
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Async reset mid SAD_WAIT (count = 2).
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    idex_mem_read = 1'b1; idex_rt = 5'd7; id_rs = 5'd7;
    id_sad_op = 1'b0; branch_taken = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_stall",    32'(stall),    32'd0);
    check("midrst_pc_write", 32'(pc_write), 32'd1);
    wait_left = 0;
    stat_cnt  = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic with a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 2) == 0,
           REG_W'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 3)),
           REG_W'($urandom_range(0, 3)),
           ($urandom % 2) == 0,
           ($urandom % 4) == 0,
           ($urandom % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_hazard_stall_unit
`default_nettype wire
